// File: rtl/grover_job_scheduler_if.sv
// grover_job_scheduler_if: requester, response and engine pins of the grover job scheduler
interface grover_job_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_BIT = 3,
  parameter int FP_BIT  = 8
);
  localparam int IDW        = $clog2(NUM_REQ);
  localparam int NUM_SAMPLE = 2 ** NUM_BIT;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*NUM_BIT-1:0]   req_target;
  logic [NUM_REQ-1:0]           ack;
  logic                         busy;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [IDW-1:0]               resp_id;
  logic [NUM_BIT-1:0]           resp_index;
  logic [FP_BIT-1:0]            resp_amp;
  logic                         resp_timeout;
  logic                         eng_rst;
  logic                         eng_start;
  logic [NUM_BIT-1:0]           eng_target;
  logic                         eng_done;
  logic [NUM_SAMPLE*FP_BIT-1:0] eng_amp;
  modport master (
    output req, req_target, resp_ready, eng_done, eng_amp,
    input  ack, busy, resp_valid, resp_id, resp_index, resp_amp, resp_timeout,
           eng_rst, eng_start, eng_target
  );
  modport slave (
    input  req, req_target, resp_ready, eng_done, eng_amp,
    output ack, busy, resp_valid, resp_id, resp_index, resp_amp, resp_timeout,
           eng_rst, eng_start, eng_target
  );
endinterface

// File: rtl/grover_job_scheduler.sv
// grover_job_scheduler: round-robin sharing of one grover engine with timeout and serial argmax scan
module grover_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_BIT     = 3,
  parameter int FP_BIT      = 8,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  grover_job_scheduler_if.slave bus
);
  localparam int IDW        = $clog2(NUM_REQ);
  localparam int NUM_SAMPLE = 2 ** NUM_BIT;
  localparam int CW         = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, GRANT, START, RUN, SCAN, RESP} state_t;
  state_t                   r_state;
  logic [NUM_REQ-1:0]       r_ack;
  logic [IDW-1:0]           r_ptr, r_resp_id, w_win, w_sel;
  logic [NUM_BIT-1:0]       r_eng_target, r_resp_index, r_k, r_idx, w_tgt;
  logic signed [FP_BIT-1:0] r_resp_amp, r_max, w_amp;
  logic [CW-1:0]            r_cnt;
  logic                     r_busy, r_resp_valid, r_resp_timeout, r_eng_rst, r_eng_start;
  logic                     w_any, w_gt;
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sel = '0;
    w_tgt = '0;
    w_amp = '0;
    // descending offset so the last hit is the one closest to ptr
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sel = IDW'((int'(r_ptr) + i) % NUM_REQ);
      if (bus.req[w_sel]) begin
        w_any = 1'b1;
        w_win = w_sel;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (w_win == IDW'(i)) w_tgt = bus.req_target[i*NUM_BIT +: NUM_BIT];
    for (int k = 0; k < NUM_SAMPLE; k++)
      if (r_k == NUM_BIT'(k)) w_amp = bus.eng_amp[k*FP_BIT +: FP_BIT];
    w_gt = (r_k == '0) || (w_amp > r_max);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_ack          <= '0;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_index   <= '0;
      r_resp_amp     <= '0;
      r_resp_timeout <= 1'b0;
      r_eng_rst      <= 1'b1;
      r_eng_start    <= 1'b0;
      r_eng_target   <= '0;
      r_cnt          <= '0;
      r_k            <= '0;
      r_idx          <= '0;
      r_max          <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state      <= GRANT;
          r_ack        <= NUM_REQ'(1) << w_win;
          r_busy       <= 1'b1;
          r_eng_target <= w_tgt;
          r_resp_id    <= w_win;
          r_ptr        <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
        GRANT: begin
          r_state     <= START;
          r_ack       <= '0;
          r_eng_rst   <= 1'b0;
          r_eng_start <= 1'b1;
          r_cnt       <= '0;
        end
        START: begin
          r_state     <= RUN;
          r_eng_start <= 1'b0;
        end
        RUN: if (bus.eng_done) begin
          r_state <= SCAN;
          r_k     <= '0;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          r_state        <= RESP;
          r_resp_valid   <= 1'b1;
          r_resp_timeout <= 1'b1;
          r_resp_index   <= '0;
          r_resp_amp     <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        SCAN: begin
          if (w_gt) begin
            r_max <= w_amp;
            r_idx <= r_k;
          end
          if (&r_k) begin
            r_state        <= RESP;
            r_resp_valid   <= 1'b1;
            r_resp_timeout <= 1'b0;
            r_resp_index   <= w_gt ? r_k : r_idx;
            r_resp_amp     <= w_gt ? w_amp : r_max;
          end
          r_k <= r_k + 1'b1;
        end
        RESP: if (bus.resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_eng_rst    <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack          = r_ack;
  assign bus.busy         = r_busy;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_resp_id;
  assign bus.resp_index   = r_resp_index;
  assign bus.resp_amp     = r_resp_amp;
  assign bus.resp_timeout = r_resp_timeout;
  assign bus.eng_rst      = r_eng_rst;
  assign bus.eng_start    = r_eng_start;
  assign bus.eng_target   = r_eng_target;
endmodule

// File: tb/tb_grover_job_scheduler.sv
// tb_grover_job_scheduler: directed vector table plus corner-case sequences against a small engine model
module tb_grover_job_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic e_done = 1'b0;
  logic e_on = 1'b0;
  int   e_cnt = 0;
  int   e_dly = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  grover_job_scheduler_if #(.NUM_REQ(4), .NUM_BIT(3), .FP_BIT(8)) bus ();
  grover_job_scheduler #(.NUM_REQ(4), .NUM_BIT(3), .FP_BIT(8), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  assign bus.eng_done = e_done;
  // engine stand-in: raises done e_dly cycles after the start strobe, never when e_dly is 0
  always @(posedge clk) begin
    if (bus.eng_rst) begin
      e_on   <= 1'b0;
      e_cnt  <= 0;
      e_done <= 1'b0;
    end else if (bus.eng_start) begin
      e_on  <= 1'b1;
      e_cnt <= 0;
    end else if (e_on && e_dly != 0) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt + 1 == e_dly) e_done <= 1'b1;
    end
  end
  typedef struct {
    logic [3:0]  rq;
    logic [11:0] tgt;
    logic [63:0] amps;
    int          dly;
    int          ack;
    int          tgt_exp;
    int          id;
    int          idx;
    int          amp;
    int          to;
    int          lat;
  } vec_t;
  localparam logic [63:0] A0 = {8'h08, 8'h08, 8'h5A, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask
  task automatic do_job(input vec_t v, input bit keep);
    int n;
    bus.req        = v.rq;
    bus.req_target = v.tgt;
    bus.eng_amp    = v.amps;
    e_dly          = v.dly;
    n = 0;
    while (bus.ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack", int'(bus.ack), v.ack);
    chk("eng_target", int'(bus.eng_target), v.tgt_exp);
    chk("busy_grant", int'(bus.busy), 1);
    chk("eng_rst_grant", int'(bus.eng_rst), 1);
    if (!keep) bus.req = '0;
    @(negedge clk);
    chk("eng_start", int'(bus.eng_start), 1);
    chk("eng_rst_start", int'(bus.eng_rst), 0);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid", int'(bus.resp_valid), 1);
    chk("latency", n, v.lat);
    chk("resp_id", int'(bus.resp_id), v.id);
    chk("resp_index", int'(bus.resp_index), v.idx);
    chk("resp_amp", int'($signed(bus.resp_amp)), v.amp);
    chk("resp_timeout", int'(bus.resp_timeout), v.to);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_valid_drop", int'(bus.resp_valid), 0);
    chk("eng_rst_idle", int'(bus.eng_rst), 1);
    chk("busy_idle", int'(bus.busy), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"}, int'(bus.ack), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
    chk({tag, "_resp_id"}, int'(bus.resp_id), 0);
    chk({tag, "_resp_index"}, int'(bus.resp_index), 0);
    chk({tag, "_resp_amp"}, int'(bus.resp_amp), 0);
    chk({tag, "_resp_timeout"}, int'(bus.resp_timeout), 0);
    chk({tag, "_eng_rst"}, int'(bus.eng_rst), 1);
    chk({tag, "_eng_start"}, int'(bus.eng_start), 0);
    chk({tag, "_eng_target"}, int'(bus.eng_target), 0);
  endtask
  initial begin
    vec_t vt[6];
    vec_t v;
    int   n;
    int   bad;
    logic [1:0] s_id;
    logic [2:0] s_idx;
    logic [7:0] s_amp;
    logic       s_to;
    vt[0] = '{4'b0001, 12'h005, A0, 6, 1, 5, 0, 5, 90, 0, 16};
    vt[1] = '{4'b0100, 12'h0C0, {8'h00, 8'h14, 8'h05, 8'h80, 8'h14, 8'h14, 8'hD8, 8'hFD},
              3, 4, 3, 2, 2, 20, 0, 13};
    vt[2] = '{4'b0011, 12'h031, {8{8'h80}}, 2, 1, 1, 0, 0, -128, 0, 12};
    vt[3] = '{4'b1001, 12'hE00, {8'h1E, 8'h14, 8'h0A, 8'h00, 8'hF6, 8'hEC, 8'hE2, 8'hD8},
              1, 8, 7, 3, 7, 30, 0, 11};
    vt[4] = '{4'b0010, 12'h010, A0, 0, 2, 2, 1, 0, 0, 1, 33};
    vt[5] = '{4'b0100, 12'h100, {8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'hFF},
              4, 4, 4, 2, 6, 127, 0, 14};
    bus.req        = '0;
    bus.req_target = '0;
    bus.resp_ready = 1'b0;
    bus.eng_amp    = A0;
    do_reset();
    @(negedge clk);
    chk_reset_state("reset");
    for (int i = 0; i < 6; i++) do_job(vt[i], 1'b0);
    // round robin with all requesters held high and the consumer always ready
    do_reset();
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      v = '{4'b1111, 12'h688, A0, 2, 1 << (j % 4), j % 4, j % 4, 5, 90, 0, 12};
      do_job(v, 1'b1);
    end
    bus.req = '0;
    // backpressure: hold the response while requester 1 waits
    bus.req = 4'b0001;
    e_dly   = 2;
    n = 0;
    while (bus.ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ack0", int'(bus.ack), 1);
    bus.req = '0;
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", int'(bus.resp_valid), 1);
    s_id  = bus.resp_id;
    s_idx = bus.resp_index;
    s_amp = bus.resp_amp;
    s_to  = bus.resp_timeout;
    chk("bp_idx", int'(s_idx), 5);
    bus.req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bad = int'(!bus.resp_valid || bus.resp_id != s_id || bus.resp_index != s_idx ||
                 bus.resp_amp != s_amp || bus.resp_timeout != s_to || bus.ack != '0);
      chk("bp_hold", bad, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp_ack_idle", int'(bus.ack), 0);
    chk("bp_drop", int'(bus.resp_valid), 0);
    v = '{4'b0010, 12'h688, A0, 2, 2, 1, 1, 5, 90, 0, 12};
    do_job(v, 1'b0);
    // reset during SCAN discards the job and rewinds the pointer
    bus.req = 4'b0100;
    e_dly   = 2;
    n = 0;
    while (bus.ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_ack", int'(bus.ack), 4);
    bus.req = '0;
    n = 0;
    while (!e_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_done", int'(e_done), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_state("mid");
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.ack != '0) bad++;
    end
    chk("mid_no_resp", bad, 0);
    v = '{4'b1001, 12'h688, A0, 2, 1, 0, 0, 5, 90, 0, 12};
    do_job(v, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/grover_job_scheduler.md
Name: grover_job_scheduler

Overview:
- Shares one grover search engine between NUM_REQ independent requesters.
- Round-robin arbitration picks a requester. The block clears the engine, starts it with that requester's target, and waits for done or a timeout.
- It then serially scans the final amplitude vector for the signed maximum and returns a tagged result.
- It sits between the requester fabric and the engine's clk/rst/start/target/done/amplitude pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_BIT, 3, search index width; engine sample count NUM_SAMPLE = 2**NUM_BIT
FP_BIT, 8, signed fixed-point amplitude width
TIMEOUT_CYC, 32, max RUN cycles without eng_done before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester request level; held until matching ack
req_target  in  NUM_REQ*NUM_BIT  per-requester target index, slice i = requester i
ack  out  NUM_REQ  one-cycle one-hot grant pulse; target captured this cycle
busy  out  1  high from GRANT through RESP inclusive
resp_valid  out  1  result available; held until resp_ready
resp_ready  in  1  result consumer handshake
resp_id  out  clog2(NUM_REQ)  requester served
resp_index  out  NUM_BIT  argmax sample index
resp_amp  out  FP_BIT  signed amplitude at resp_index
resp_timeout  out  1  engine did not finish; index/amp forced to 0
eng_rst  out  1  active-high engine reset
eng_start  out  1  engine start strobe
eng_target  out  NUM_BIT  engine search target
eng_done  in  1  engine completion level
eng_amp  in  NUM_SAMPLE*FP_BIT  engine amplitudes, slice k = sample k, signed

Behaviour:
- Interface rules:
  - Single clock domain. rst_n is sampled only on the rising edge of clk.
  - All outputs are registered.
- Reset values:
  - ack=0, busy=0, resp_valid=0, resp_id=0, resp_index=0, resp_amp=0, resp_timeout=0.
  - eng_rst=1, eng_start=0, eng_target=0.
  - Round-robin pointer=0, state=IDLE.
- Reset mid-operation: rst_n low in any state aborts the job; any pending response is discarded (never presented); eng_rst=1 from the next edge.
- FSM states: IDLE, GRANT, START, RUN, SCAN, RESP.
- IDLE:
  - eng_rst=1.
  - If any req bit is high, choose the first set bit scanning from ptr upward with wrap, then go to GRANT.
- GRANT (1 cycle):
  - ack[winner]=1, eng_target<=req_target[winner], resp_id<=winner, ptr<=(winner+1) mod NUM_REQ.
  - eng_rst stays 1.
- START (1 cycle): eng_rst=0, eng_start=1; clear the RUN cycle counter.
- RUN:
  - eng_start=0, eng_rst=0; the counter increments each cycle.
  - If eng_done=1, go to SCAN (done has priority over timeout in the same cycle).
  - Otherwise, when the counter reaches TIMEOUT_CYC-1, go to RESP with resp_timeout=1, resp_index=0, resp_amp=0.
- SCAN (exactly NUM_SAMPLE cycles):
  - Cycle k compares signed eng_amp slice k against the running max. The first sample initialises the max.
  - Replace only on strictly greater, so ties resolve to the lowest index.
  - After sample NUM_SAMPLE-1 go to RESP with resp_timeout=0.
  - eng_amp must stay stable during SCAN; the engine is held (eng_rst=0, start=0).
- RESP:
  - resp_valid=1; resp_* stay stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1, resp_valid drops at the next edge and the FSM returns to IDLE; eng_rst=1 again from that IDLE cycle.
  - resp_ready is ignored outside RESP.
- Latency: req sampled in IDLE at edge N -> ack at N+1 -> eng_start at N+2 -> first RUN at N+3. eng_done seen at edge D -> resp_valid at D+NUM_SAMPLE+1.
- Arbitration and request handling:
  - New requests are never acked while busy=1; they remain pending.
  - A req deasserted before ack is simply not considered.
  - Back-to-back requests cost minimum one IDLE cycle between jobs.
- Width rules: amplitudes are compared as signed FP_BIT values, with no extension or saturation.

Test Plan:
- Single job:
  - Stimulus: req=0001, target=5; bench engine asserts done 6 cycles after start with amp[5]=+90, others=+8.
  - Response: ack=0001 one cycle; eng_start one cycle two edges after req; resp_id=0, resp_index=5, resp_amp=90, resp_timeout=0.
- Round-robin:
  - Stimulus: req=1111 held throughout, resp_ready=1.
  - Response: grant order 0,1,2,3,0; exactly one ack bit per GRANT; eng_rst high one full IDLE+GRANT span between jobs.
- Ties and negatives:
  - Stimulus: amps = {-3,-40,+20,+20,-128,+5,+20,0} (index 0 first).
  - Response: resp_index=2, resp_amp=20. A second vector of all -128 gives resp_index=0, resp_amp=-128.
- Timeout:
  - Stimulus: engine never asserts done, TIMEOUT_CYC=32.
  - Response: resp_valid exactly 32 RUN cycles after START; resp_timeout=1, index=0, amp=0. The next job proceeds normally.
- Backpressure:
  - Stimulus: resp_ready held low 10 cycles, req=0010 pending meanwhile.
  - Response: resp_* stable for 10 cycles; no ack for requester 1 until after the resp_ready handshake.
- Reset mid-job:
  - Stimulus: rst_n low 1 cycle during SCAN.
  - Response: all outputs return to reset values (eng_rst=1, resp_valid=0); no response for the aborted job; ptr=0, so requester 0 wins next.
